// File: rtl/shift_pkg.sv
// Shared encodings for the multi-cycle shifter.
package shift_pkg;

  localparam logic [1:0] MODE_SLL  = 2'b00;
  localparam logic [1:0] MODE_SRL  = 2'b01;
  localparam logic [1:0] MODE_SRA  = 2'b10;
  localparam logic [1:0] MODE_ROTR = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_e;

endpackage

// File: rtl/shift_step.sv
// One iteration of the shifter: shifts data by k (0..STEP) bits in the given mode.
// Built as a mux barrel, stage j conditionally shifting by 2**j.
module shift_step
  import shift_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEP  = 1,
  localparam int NST  = $clog2(STEP) + 1
) (
  input  logic [WIDTH-1:0] data_i,
  input  logic [NST-1:0]   k_i,
  input  logic [1:0]       mode_i,
  output logic [WIDTH-1:0] data_o
);

  // Fixed-distance shift; sh may equal WIDTH on the top stage when STEP==WIDTH,
  // where every form below still degenerates cleanly (zero / sign / identity).
  function automatic logic [WIDTH-1:0] sh_by(input logic [WIDTH-1:0] d, input int sh,
                                             input logic [1:0] m);
    logic [WIDTH-1:0] r;
    case (m)
      MODE_SLL: r = d << sh;
      MODE_SRL: r = d >> sh;
      MODE_SRA: r = $unsigned($signed(d) >>> sh);
      default:  r = (d >> sh) | (d << (WIDTH - sh));
    endcase
    return r;
  endfunction

  logic [NST:0][WIDTH-1:0] stg;

  assign stg[0] = data_i;

  for (genvar j = 0; j < NST; j++) begin : g_stage
    assign stg[j+1] = k_i[j] ? sh_by(stg[j], (1 << j), mode_i) : stg[j];
  end

  assign data_o = stg[NST];

endmodule

// File: rtl/shift_unit_seq.sv
// Multi-cycle shifter (SLL/SRL/SRA/ROTR), up to STEP bits per cycle,
// valid/ready on both request and result sides.
module shift_unit_seq
  import shift_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int STEP    = 1,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [SHAMT_W-1:0] in_shamt,
  input  logic [1:0]         in_mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic               busy
);

  localparam int KW = $clog2(STEP) + 1;
  localparam logic [SHAMT_W:0] STEP_V = (SHAMT_W+1)'(STEP);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   data_q, data_d;
  logic [SHAMT_W-1:0] rem_q, rem_d;
  logic [1:0]         mode_q, mode_d;

  logic [SHAMT_W:0]   k_full;
  logic [WIDTH-1:0]   step_data;

  // k = min(rem, STEP); widened by one bit so STEP==WIDTH is representable.
  assign k_full = ({1'b0, rem_q} > STEP_V) ? STEP_V : {1'b0, rem_q};

  shift_step #(.WIDTH(WIDTH), .STEP(STEP)) u_step (
    .data_i (data_q),
    .k_i    (k_full[KW-1:0]),
    .mode_i (mode_q),
    .data_o (step_data)
  );

  // Next-state: accept in IDLE, iterate in SHIFT until rem hits 0, hold in DONE.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    rem_d   = rem_q;
    mode_d  = mode_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          data_d  = in_data;
          rem_d   = in_shamt;
          mode_d  = in_mode;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (rem_q == '0) begin
          state_d = ST_DONE;
        end else begin
          data_d = step_data;
          rem_d  = rem_q - k_full[SHAMT_W-1:0];
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset discards any in-flight op.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      data_q  <= '0;
      rem_q   <= '0;
      mode_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      rem_q   <= rem_d;
      mode_q  <= mode_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q != ST_IDLE);
  assign out_data  = data_q;

endmodule

// File: tb/tb_shift_unit_seq.sv
// Directed + random bench for shift_unit_seq; several STEP variants run in lockstep.
module tb_shift_unit_seq;

  localparam int W  = 32;
  localparam int ND = 5;
  localparam int STEPS [ND] = '{1, 2, 4, 8, 32};

  logic clk = 1'b0;
  logic reset;
  logic in_valid, out_ready;
  logic [W-1:0] in_data;
  logic [4:0]   in_shamt;
  logic [1:0]   in_mode;
  logic [ND-1:0]        in_ready, out_valid, busy;
  logic [ND-1:0][W-1:0] out_data;

  always #5 clk = ~clk;

  for (genvar g = 0; g < ND; g++) begin : g_dut
    shift_unit_seq #(.WIDTH(W), .STEP(STEPS[g])) u_dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready[g]),
      .in_data   (in_data),
      .in_shamt  (in_shamt),
      .in_mode   (in_mode),
      .out_valid (out_valid[g]),
      .out_ready (out_ready),
      .out_data  (out_data[g]),
      .busy      (busy[g])
    );
  end

  int n_run  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] ref_shift(input logic [1:0] m, input logic [W-1:0] d,
                                             input int sh);
    case (m)
      2'b00:   return d << sh;
      2'b01:   return d >> sh;
      2'b10:   return $unsigned($signed(d) >>> sh);
      default: return (sh == 0) ? d : ((d >> sh) | (d << (W - sh)));
    endcase
  endfunction

  function automatic int lat_of(input int sh, input int st);
    return (sh + st - 1) / st + 1;
  endfunction

  // Issue one op to every DUT at a negedge; track latency, data and handshake count.
  // hold>0: keep out_ready low for hold cycles once every result is up.
  task automatic run_op(input logic [1:0] m, input logic [W-1:0] d, input int sh,
                        input bit bp, input int hold, input string tag);
    logic [W-1:0] exp;
    int  lat[ND];
    int  xfer[ND];
    int  e, hc;
    bit  done, allv;
    exp = ref_shift(m, d, sh);
    for (int i = 0; i < ND; i++) begin
      lat[i]  = -1;
      xfer[i] = 0;
    end
    chk({tag, " in_ready"}, 64'(in_ready), 64'({ND{1'b1}}));
    in_valid  = 1'b1;
    in_data   = d;
    in_shamt  = 5'(sh);
    in_mode   = m;
    out_ready = (hold > 0) ? 1'b0 : 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = $urandom;
    in_shamt = 5'($urandom);
    in_mode  = 2'($urandom);
    e = 0; hc = 0; done = 1'b0;
    for (int c = 0; c < 400 && !done; c++) begin
      @(negedge clk);
      done = (in_ready == {ND{1'b1}});
      for (int i = 0; i < ND; i++) if (xfer[i] == 0) done = 1'b0;
      if (!done) begin
        for (int i = 0; i < ND; i++) begin
          if (out_valid[i] && lat[i] < 0) begin
            lat[i] = e;
            chk($sformatf("%s s%0d data", tag, STEPS[i]), 64'(out_data[i]), 64'(exp));
            chk($sformatf("%s s%0d lat", tag, STEPS[i]), 64'(e), 64'(lat_of(sh, STEPS[i])));
          end
        end
        allv = 1'b1;
        for (int i = 0; i < ND; i++) if (lat[i] < 0) allv = 1'b0;
        if (hold > 0 && hc < hold) begin
          out_ready = 1'b0;
          if (allv) begin
            for (int i = 0; i < ND; i++) begin
              chk($sformatf("%s hold s%0d ov", tag, STEPS[i]), 64'(out_valid[i]), 64'd1);
              chk($sformatf("%s hold s%0d data", tag, STEPS[i]), 64'(out_data[i]), 64'(exp));
              chk($sformatf("%s hold s%0d ir", tag, STEPS[i]), 64'(in_ready[i]), 64'd0);
            end
            hc++;
          end
        end else begin
          out_ready = bp ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
        for (int i = 0; i < ND; i++) if (out_valid[i] && out_ready) xfer[i]++;
        @(posedge clk);
        e++;
      end
    end
    for (int i = 0; i < ND; i++)
      chk($sformatf("%s s%0d xfers", tag, STEPS[i]), 64'(xfer[i]), 64'd1);
    out_ready = 1'b1;
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    in_data   = '0;
    in_shamt  = '0;
    in_mode   = '0;
    #1;
    for (int i = 0; i < ND; i++) begin
      chk($sformatf("rst s%0d in_ready", STEPS[i]), 64'(in_ready[i]), 64'd1);
      chk($sformatf("rst s%0d out_valid", STEPS[i]), 64'(out_valid[i]), 64'd0);
      chk($sformatf("rst s%0d out_data", STEPS[i]), 64'(out_data[i]), 64'd0);
      chk($sformatf("rst s%0d busy", STEPS[i]), 64'(busy[i]), 64'd0);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Directed vectors
    run_op(2'b00, 32'hAAAAAAAA, 2, 1'b0, 0, "sll2");
    run_op(2'b10, 32'h80000000, 4, 1'b0, 0, "sra4");
    run_op(2'b01, 32'h80000000, 4, 1'b0, 0, "srl4");
    run_op(2'b11, 32'h12345678, 8, 1'b0, 0, "rotr8");
    run_op(2'b01, 32'hFFFFFFFF, 31, 1'b0, 0, "srl31");
    run_op(2'b10, 32'h7FFF0000, 31, 1'b0, 0, "sra31p");
    run_op(2'b11, 32'h00000001, 31, 1'b0, 0, "rotr31");
    for (int m = 0; m < 4; m++)
      run_op(2'(m), 32'h0000FFFF, 0, 1'b0, 5, $sformatf("sh0m%0d", m));

    // Reset in the middle of a long shift
    in_valid = 1'b1; in_data = 32'h12345678; in_shamt = 5'd20; in_mode = 2'b00;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    for (int i = 0; i < ND; i++) begin
      chk($sformatf("mrst s%0d busy", STEPS[i]), 64'(busy[i]), 64'd0);
      chk($sformatf("mrst s%0d out_valid", STEPS[i]), 64'(out_valid[i]), 64'd0);
      chk($sformatf("mrst s%0d out_data", STEPS[i]), 64'(out_data[i]), 64'd0);
      chk($sformatf("mrst s%0d in_ready", STEPS[i]), 64'(in_ready[i]), 64'd1);
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("post-rst no result", 64'(out_valid), 64'd0);
    end
    run_op(2'b00, 32'h00000001, 31, 1'b0, 0, "sll31");

    // Random sweep with backpressure
    for (int n = 0; n < 1000; n++)
      run_op(2'($urandom), $urandom, $urandom_range(0, 31), 1'b1, 0, $sformatf("rnd%0d", n));

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
